// File: rtl/redmule_periph_driver.sv
// redmule_periph_driver
//   Peripheral-port initiator that runs one RedMulE job through the HWPE
//   control slave. For each job it acquires a context, writes the job
//   register block, writes the trigger, waits for the completion event and
//   then reports the acquired job ID.
//
// Optional feature: define REDMULE_DRV_TIMEOUT_EN to add a watchdog in
//   WAIT_EVT. On expiry the driver writes a soft clear, pulses timeout_o and
//   returns to IDLE without done_o. Without the macro, timeout_o is tied 0 and
//   WAIT_EVT waits forever.
//
// Ports:
//   clk_i, rst_ni        clock, synchronous active-low reset
//   job_valid_i/ready_o  job descriptor handshake (ready only in IDLE)
//   job_regs_i           NUM_REGS x 32-bit register values, captured on handshake
//   done_o, job_id_o     one-cycle completion pulse with the acquired job ID
//   busy_o               high whenever the FSM is not in IDLE
//   timeout_o            one-cycle watchdog pulse (optional feature)
//   evt_i                accelerator event lines, bit EVT_IDX is completion
//   periph_*             peripheral initiator port (req/gnt, response r_*)
//
// Handshake semantics: periph_req_o, periph_add_o, periph_wen_o and
//   periph_data_o hold steady until the cycle where req & gnt are both high;
//   that cycle completes the transfer. A read response is accepted on any
//   later cycle with periph_r_valid_i high; only one read is ever outstanding.

module redmule_periph_driver #(
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned NUM_REGS       = 12,
  parameter logic [31:0] REG_BASE       = 32'h40,
  parameter logic [31:0] BASE_ADDR      = 32'h0,
  parameter int unsigned RETRY_WAIT     = 4,
  parameter int unsigned EVT_IDX        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     job_valid_i,
  output logic                     job_ready_o,
  input  logic [NUM_REGS*32-1:0]   job_regs_i,
  output logic                     done_o,
  output logic [7:0]               job_id_o,
  output logic                     busy_o,
  output logic                     timeout_o,
  input  logic [1:0]               evt_i,
  output logic                     periph_req_o,
  input  logic                     periph_gnt_i,
  output logic [31:0]              periph_add_o,
  output logic                     periph_wen_o,
  output logic [3:0]               periph_be_o,
  output logic [31:0]              periph_data_o,
  output logic [ID_WIDTH-1:0]      periph_id_o,
  input  logic [31:0]              periph_r_data_i,
  input  logic                     periph_r_valid_i,
  input  logic [ID_WIDTH-1:0]      periph_r_id_i
);

  localparam int unsigned CNT_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [CNT_W-1:0] LAST_REG = CNT_W'(NUM_REGS - 1);

  localparam logic [31:0] OFF_TRIGGER = 32'h00;
  localparam logic [31:0] OFF_ACQUIRE = 32'h04;
  localparam logic [31:0] OFF_SOFTCLR = 32'h14;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ACQ_REQ,
    S_ACQ_RSP,
    S_BACKOFF,
    S_WR_REGS,
    S_TRIGGER,
    S_WAIT_EVT,
    S_SOFT_CLR,
    S_TMO,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      regs_q [NUM_REGS];
  logic [CNT_W-1:0] reg_cnt_q;
  logic [31:0]      wait_cnt_q;
  logic [7:0]       job_id_q;
  logic             wait_cnt_run;

  // ---------------------------------------------------------------------------
  // State register and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (state_q == S_IDLE && job_valid_i) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= job_regs_i[i*32 +: 32];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg_cnt_q <= '0;
    end else if (state_q == S_ACQ_RSP) begin
      reg_cnt_q <= '0;
    end else if (state_q == S_WR_REGS && periph_gnt_i) begin
      reg_cnt_q <= (reg_cnt_q == LAST_REG) ? '0 : reg_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      job_id_q <= '0;
    end else if (state_q == S_ACQ_RSP && periph_r_valid_i && !periph_r_data_i[31]) begin
      job_id_q <= periph_r_data_i[7:0];
    end
  end

  // One counter serves both the acquire back-off and the watchdog; it restarts
  // from zero on every state change.
`ifdef REDMULE_DRV_TIMEOUT_EN
  assign wait_cnt_run = (state_q == S_BACKOFF) || (state_q == S_WAIT_EVT);
`else
  assign wait_cnt_run = (state_q == S_BACKOFF);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
    end else if (state_d != state_q || !wait_cnt_run) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and peripheral request outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    periph_req_o  = 1'b0;
    periph_add_o  = '0;
    periph_wen_o  = 1'b0;
    periph_data_o = '0;

    case (state_q)
      S_IDLE: begin
        if (job_valid_i) state_d = S_ACQ_REQ;
      end
      S_ACQ_REQ: begin
        periph_req_o = 1'b1;
        periph_wen_o = 1'b1;
        periph_add_o = BASE_ADDR + OFF_ACQUIRE;
        if (periph_gnt_i) state_d = S_ACQ_RSP;
      end
      S_ACQ_RSP: begin
        if (periph_r_valid_i) begin
          // bit 31 set means no free context: retry after a pause
          if (periph_r_data_i[31]) state_d = (RETRY_WAIT == 0) ? S_ACQ_REQ : S_BACKOFF;
          else                     state_d = S_WR_REGS;
        end
      end
      S_BACKOFF: begin
        if (wait_cnt_q == 32'(RETRY_WAIT - 1)) state_d = S_ACQ_REQ;
      end
      S_WR_REGS: begin
        periph_req_o  = 1'b1;
        periph_add_o  = BASE_ADDR + REG_BASE + (32'(reg_cnt_q) << 2);
        periph_data_o = regs_q[reg_cnt_q];
        if (periph_gnt_i && reg_cnt_q == LAST_REG) state_d = S_TRIGGER;
      end
      S_TRIGGER: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + OFF_TRIGGER;
        if (periph_gnt_i) state_d = S_WAIT_EVT;
      end
      S_WAIT_EVT: begin
        // the completion event wins over a watchdog expiry in the same cycle
        if (evt_i[EVT_IDX]) state_d = S_DONE;
`ifdef REDMULE_DRV_TIMEOUT_EN
        else if (wait_cnt_q == 32'(TIMEOUT_CYCLES - 1)) state_d = S_SOFT_CLR;
`endif
      end
      S_SOFT_CLR: begin
        periph_req_o = 1'b1;
        periph_add_o = BASE_ADDR + OFF_SOFTCLR;
        if (periph_gnt_i) state_d = S_TMO;
      end
      S_TMO:   state_d = S_IDLE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign job_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE);
  assign job_id_o    = done_o ? job_id_q : 8'h00;
  assign periph_be_o = 4'hF;
  assign periph_id_o = '0;

`ifdef REDMULE_DRV_TIMEOUT_EN
  assign timeout_o = (state_q == S_TMO);
`else
  assign timeout_o = 1'b0;
`endif

  // Response ID, upper read-data bits and the non-selected event line carry
  // nothing this driver acts on.
  logic unused_in;
  assign unused_in = ^{periph_r_id_i, periph_r_data_i[30:8], evt_i};

endmodule

// File: tb/tb_redmule_periph_driver.sv
module tb_redmule_periph_driver;

  localparam int NR = 12;
  localparam int W  = 65;   // {wen, add, data}

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT signals
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              job_valid = 1'b0;
  logic              job_ready;
  logic [NR*32-1:0]  job_regs = '0;
  logic              done;
  logic [7:0]        job_id;
  logic              busy;
  logic              timeout;
  logic              evt_tb = 1'b0;
  logic              evt_rsp = 1'b0;
  logic [1:0]        evt;
  logic              req;
  logic              gnt = 1'b1;
  logic [31:0]       add;
  logic              wen;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [7:0]        pid;
  logic [31:0]       r_data = '0;
  logic              r_valid = 1'b0;
  logic [7:0]        r_id = '0;

  assign evt = {1'b0, evt_tb | evt_rsp};

  always #5 clk = ~clk;

  redmule_periph_driver #(.TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .job_valid_i(job_valid), .job_ready_o(job_ready), .job_regs_i(job_regs),
    .done_o(done), .job_id_o(job_id), .busy_o(busy), .timeout_o(timeout),
    .evt_i(evt),
    .periph_req_o(req), .periph_gnt_i(gnt), .periph_add_o(add),
    .periph_wen_o(wen), .periph_be_o(be), .periph_data_o(wdata),
    .periph_id_o(pid), .periph_r_data_i(r_data), .periph_r_valid_i(r_valid),
    .periph_r_id_i(r_id)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  obs_q[$];
  int            obs_cyc_q[$];
  logic [31:0]   rsp_q[$];
  logic [31:0]   stall_add_q[$];
  logic [31:0]   stall_dat_q[$];
  logic [31:0]   desc [NR];

  int cyc = 0;
  int hs_cyc = 0;
  int done_n = 0, done_cyc = 0;
  logic [7:0] done_id = '0;
  int tmo_n = 0, tmo_cyc = 0;
  int evt_delay = 0;
  int evt_cd = 0;
  int stall_left = 0;
  logic rd_pend = 1'b0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Slave model: runs on the falling edge, drives gnt/r_valid/evt and logs
  // every completed transfer and every done/timeout pulse.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    cyc++;
    if (rd_pend) begin
      r_valid = 1'b1;
      r_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 32'h0;
      rd_pend = 1'b0;
    end else begin
      r_valid = 1'b0;
      r_data  = 32'h0;
    end
    evt_rsp = 1'b0;
    if (evt_cd > 0) begin
      evt_cd--;
      if (evt_cd == 0) evt_rsp = 1'b1;
    end
    gnt = 1'b1;
    if (req && !wen && add == 32'h50 && stall_left > 0) begin
      gnt = 1'b0;
      stall_left--;
      stall_add_q.push_back(add);
      stall_dat_q.push_back(wdata);
    end
    if (req && gnt) begin
      obs_q.push_back({wen, add, wen ? 32'h0 : wdata});
      obs_cyc_q.push_back(cyc);
      if (wen) rd_pend = 1'b1;
      else if (add == 32'h0 && evt_delay > 0) evt_cd = evt_delay;
    end
    if (done) begin
      done_n++;
      done_cyc = cyc;
      done_id  = job_id;
    end
    if (timeout) begin
      tmo_n++;
      tmo_cyc = cyc;
    end
    if (job_valid && job_ready) hs_cyc = cyc;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic set_desc(input logic [31:0] base);
    for (int k = 0; k < NR; k++) begin
      desc[k] = base + 32'(k) * 32'h0101_0101;
      job_regs[k*32 +: 32] = desc[k];
    end
  endtask

  task automatic expect_job(input int n_reads);
    for (int i = 0; i < n_reads; i++) exp_q.push_back({1'b1, 32'h04, 32'h0});
    for (int k = 0; k < NR; k++) exp_q.push_back({1'b0, 32'h40 + 32'(k) * 32'd4, desc[k]});
    exp_q.push_back({1'b0, 32'h0, 32'h0});
  endtask

  task automatic compare_log(input string tag);
    check({tag, "_txn_count"}, W'(obs_q.size()), W'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_txn"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_logs();
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
  endtask

  task automatic start_job();
    @(posedge clk); #1 job_valid = 1'b1;
    @(posedge clk); #1 job_valid = 1'b0;
  endtask

  // Starts a job and waits (bounded) for done_o or timeout_o; returns latency
  // from the descriptor handshake cycle.
  task automatic run_job(input int d, output int lat, output int d_done, output int d_tmo);
    int d0, t0, n;
    d0 = done_n;
    t0 = tmo_n;
    n  = 0;
    evt_delay = d;
    start_job();
    while (done_n == d0 && tmo_n == t0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check("job_end_reached", W'(done_n != d0 || tmo_n != t0), W'(1));
    lat = (done_n != d0) ? done_cyc - hs_cyc : tmo_cyc - hs_cyc;
    repeat (3) @(posedge clk);
    #1;
    d_done = done_n - d0;
    d_tmo  = tmo_n - t0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int lat, dd, dt, n;

    repeat (3) @(posedge clk);
    #1;
    check("rst_job_ready", W'(job_ready), W'(1));
    check("rst_busy",      W'(busy),      W'(0));
    check("rst_req",       W'(req),       W'(0));
    check("rst_done",      W'(done),      W'(0));
    check("rst_timeout",   W'(timeout),   W'(0));
    check("rst_add",       W'(add),       W'(0));
    check("rst_job_id",    W'(job_id),    W'(0));
    rst_ni = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic job: event 20 cycles after trigger
    clear_logs();
    set_desc(32'h1000_0000);
    rsp_q.push_back(32'h3);
    expect_job(1);
    run_job(20, lat, dd, dt);
    compare_log("basic");
    check("basic_latency", W'(lat), W'(36));
    check("basic_done_cnt", W'(dd), W'(1));
    check("basic_job_id", W'(done_id), W'(8'h03));
    check("basic_be", W'(be), W'(4'hF));

    // Minimum latency: event on the cycle after trigger
    clear_logs();
    set_desc(32'h2200_0011);
    rsp_q.push_back(32'h0000_0042);
    expect_job(1);
    run_job(1, lat, dd, dt);
    compare_log("minlat");
    check("minlat_latency", W'(lat), W'(17));
    check("minlat_job_id", W'(done_id), W'(8'h42));

    // Busy acquire twice, then success
    clear_logs();
    set_desc(32'h3300_0000);
    rsp_q.push_back(32'hFFFF_FFFF);
    rsp_q.push_back(32'hFFFF_FFFF);
    rsp_q.push_back(32'h1);
    expect_job(3);
    run_job(1, lat, dd, dt);
    check("busy_rd_gap0", W'(obs_cyc_q[1] - obs_cyc_q[0]), W'(6));
    check("busy_rd_gap1", W'(obs_cyc_q[2] - obs_cyc_q[1]), W'(6));
    compare_log("busy");
    check("busy_latency", W'(lat), W'(29));
    check("busy_job_id", W'(done_id), W'(8'h01));

    // Grant stall for 5 cycles on register write 4 (address 0x50)
    clear_logs();
    set_desc(32'h4400_0400);
    rsp_q.push_back(32'h9);
    expect_job(1);
    stall_left = 5;
    run_job(1, lat, dd, dt);
    compare_log("stall");
    check("stall_cycles", W'(stall_add_q.size()), W'(5));
    while (stall_add_q.size() > 0) begin
      check("stall_add_stable", W'(stall_add_q.pop_front()), W'(32'h50));
      check("stall_data_stable", W'(stall_dat_q.pop_front()), W'(desc[4]));
    end
    check("stall_latency", W'(lat), W'(22));

    // Reset during WR_REGS with counter at 6
    clear_logs();
    set_desc(32'h5500_0000);
    rsp_q.push_back(32'h3);
    evt_delay = 1;
    start_job();
    n = 0;
    while (obs_q.size() < 7 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("rst_mid_reached_wr6", W'(obs_q.size()), W'(7));
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_req", W'(req), W'(0));
    check("rst_mid_busy", W'(busy), W'(0));
    check("rst_mid_ready", W'(job_ready), W'(1));
    rst_ni = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    rsp_q.delete();
    set_desc(32'h6600_0000);
    rsp_q.push_back(32'h5);
    expect_job(1);
    run_job(1, lat, dd, dt);
    compare_log("restart");
    check("restart_latency", W'(lat), W'(17));
    check("restart_job_id", W'(done_id), W'(8'h05));

    // Stray event in IDLE must not complete the next job early
    clear_logs();
    dd = done_n;
    @(posedge clk); #1 evt_tb = 1'b1;
    @(posedge clk); #1 evt_tb = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stray_no_done", W'(done_n - dd), W'(0));
    set_desc(32'h7700_0007);
    rsp_q.push_back(32'h7);
    expect_job(1);
    run_job(20, lat, dd, dt);
    compare_log("stray");
    check("stray_latency", W'(lat), W'(36));
    check("stray_done_cnt", W'(dd), W'(1));
    check("stray_job_id", W'(done_id), W'(8'h07));

`ifdef REDMULE_DRV_TIMEOUT_EN
    // Watchdog: no event at all
    clear_logs();
    set_desc(32'h8800_0000);
    rsp_q.push_back(32'h2);
    expect_job(1);
    exp_q.push_back({1'b0, 32'h14, 32'h0});
    run_job(0, lat, dd, dt);
    compare_log("tmo");
    check("tmo_pulse_cnt", W'(dt), W'(1));
    check("tmo_no_done", W'(dd), W'(0));
    check("tmo_latency", W'(lat), W'(117));
    check("tmo_back_idle", W'(job_ready), W'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/redmule_periph_driver.md
Name: redmule_periph_driver

Overview:
- Peripheral-port initiator that offloads one RedMulE job through the HWPE control slave interface.
- Sequence per job: acquires a context, writes the job register block, writes the trigger, waits for the completion event, then returns the job ID.
- Sits in the cluster testbench and the tightly-coupled controller path, in place of a core issuing the programming sequence in software.

Parameters:
- ID_WIDTH, 8, width of periph_id_o / periph_r_id_i.
- NUM_REGS, 12, number of 32-bit job registers written per job.
- REG_BASE, 32'h40, byte offset of job register 0; register k is written at REG_BASE + 4*k.
- BASE_ADDR, 32'h0, accelerator base address added to every offset.
- RETRY_WAIT, 4, idle cycles between a failed acquire and the next acquire.
- EVT_IDX, 0, index of the completion bit in evt_i.
- TIMEOUT_CYCLES, 65535, WAIT_EVT cycle limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- job_valid_i  in  1  job descriptor valid.
- job_ready_o  out  1  driver accepts a descriptor (high only in IDLE).
- job_regs_i  in  NUM_REGS*32  register values, captured on the valid&ready handshake.
- done_o  out  1  single-cycle pulse at job completion.
- job_id_o  out  8  ID returned by acquire; valid while done_o is high.
- busy_o  out  1  high in every state except IDLE.
- timeout_o  out  1  single-cycle pulse on watchdog expiry (optional feature only; tied 0 otherwise).
- evt_i  in  2  accelerator event lines for this core.
- periph_req_o  out  1  request.
- periph_gnt_i  in  1  grant.
- periph_add_o  out  32  byte address.
- periph_wen_o  out  1  1 = read, 0 = write.
- periph_be_o  out  4  byte enables; always 4'hF.
- periph_data_o  out  32  write data.
- periph_id_o  out  ID_WIDTH  transaction ID; constant 0.
- periph_r_data_i  in  32  read data.
- periph_r_valid_i  in  1  read response valid.
- periph_r_id_i  in  ID_WIDTH  response ID; ignored.

Behaviour:
- Reset, synchronous on rst_ni low: state IDLE; all outputs 0 except job_ready_o=1; register counter 0; captured job registers cleared. Reset mid-transaction abandons the transaction immediately; req drops the next cycle.
- Handshake: req, add, wen and data stay stable until the cycle in which req&gnt is high. The transaction completes on that cycle; the next request may start the following cycle.
- Read response: arrives on any later cycle with r_valid=1. Only one outstanding read is allowed.
- FSM, IDLE: on job_valid_i & job_ready_o, capture job_regs_i -> ACQ_REQ.
- FSM, ACQ_REQ: read at offset 0x04. On grant -> ACQ_RSP.
- FSM, ACQ_RSP: on r_valid, if r_data[31]=1 the context is busy -> BACKOFF; otherwise latch job_id = r_data[7:0] -> WR_REGS with counter = 0.
- FSM, BACKOFF: wait RETRY_WAIT cycles -> ACQ_REQ.
- FSM, WR_REGS: write reg[counter] at REG_BASE+4*counter. On grant, counter++; after the grant for counter == NUM_REGS-1 -> TRIGGER. Writes are back-to-back when gnt is held high: NUM_REGS cycles minimum.
- FSM, TRIGGER: write 32'h0 at offset 0x00. On grant -> WAIT_EVT.
- FSM, WAIT_EVT: on evt_i[EVT_IDX]=1 -> DONE. Events arriving in any other state are ignored and not stored.
- FSM, DONE: done_o=1 for one cycle with job_id_o valid -> IDLE.
- Addresses: BASE_ADDR + offset, 32-bit wrap-around, no overflow check.
- Minimum latency with gnt always 1, r_valid 1 cycle after grant, event immediate: 1 (ACQ_REQ) + 1 (ACQ_RSP) + NUM_REGS + 1 (TRIGGER) + 1 (WAIT_EVT) + 1 (DONE) cycles from the handshake to done_o.
- A simultaneous gnt and r_valid in ACQ_REQ is impossible by protocol; if it occurs, r_valid is ignored.

Optional Feature:
- Macro: REDMULE_DRV_TIMEOUT_EN.
- Defined: a 32-bit counter runs in WAIT_EVT. When it reaches TIMEOUT_CYCLES without the event, the driver writes 32'h0 at offset 0x14 (soft clear), pulses timeout_o for one cycle and returns to IDLE without a done_o pulse. An event arriving on the expiry cycle takes priority: normal completion, no timeout.
- Undefined: no counter, no soft-clear write, timeout_o tied 0, WAIT_EVT waits forever.

Test Plan:
- Basic job, NUM_REGS=12, gnt=1, r_data=32'h3, event 20 cycles after trigger -> exactly 12 writes at 0x40..0x6C carrying the descriptor values in order, then a write of 0 at 0x00; done_o pulses once with job_id_o=3.
- Busy acquire: r_data=32'hFFFFFFFF twice, then 32'h1 -> three reads at 0x04, spaced by RETRY_WAIT+2 cycles, then normal completion with job_id_o=1.
- Gnt stall: gnt held low for 5 cycles during register write 4 -> add=0x50 and the data stay stable for all 5 cycles; no duplicate or skipped write.
- Reset pulse asserted during WR_REGS at counter 6 -> next cycle req=0 and busy_o=0; a fresh job restarts at the acquire read.
- Stray evt_i pulse in IDLE, followed by a new job -> no early done_o; completion waits for the post-trigger event.
- REDMULE_DRV_TIMEOUT_EN with TIMEOUT_CYCLES=100 and no event -> after 100 cycles, a write of 0 at 0x14, timeout_o pulses, no done_o, state returns to IDLE.
